// File: rtl/shadow_reg_writer.sv
// shadow_reg_writer
//   Initiator side of the shadowed-register double-write protocol. Takes one
//   write request, issues two identical write strobes separated by one idle
//   cycle, reads back the committed value, retries on failure and reports
//   completion/error. value_o mirrors the last successfully committed value.
//
// Ports
//   clk_i, rst_i   clock, synchronous active-high reset
//   req_valid_i    write request valid
//   req_ready_o    ready to accept a request (IDLE only)
//   req_data_i     value to commit
//   we_o, wd_o     write strobe / data towards the shadowed register
//   qs_i           committed-value readback from the register
//   err_update_i   register-side update error (staged/shadow mismatch)
//   done_o, err_o  one-cycle completion pulse and coincident error flag
//   err_code_o     0 none, 1 readback mismatch, 2 update error
//   value_o        last successfully committed value
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a request, req_ready_o high
// WR1   | first write strobe
// GAP   | one idle cycle between strobes, wd_o held
// WR2   | second write strobe
// CHECK | compare readback and sticky update error, retry or finish
// RESP  | done_o pulse, err_code_o valid
module shadow_reg_writer #(
  parameter int              DW        = 5,
  parameter logic [DW-1:0]   RESVAL    = '0,
  parameter int              MAX_RETRY = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic [DW-1:0] req_data_i,
  output logic          we_o,
  output logic [DW-1:0] wd_o,
  input  logic [DW-1:0] qs_i,
  input  logic          err_update_i,
  output logic          done_o,
  output logic          err_o,
  output logic [1:0]    err_code_o,
  output logic [DW-1:0] value_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR1   = 3'd1,
    S_GAP   = 3'd2,
    S_WR2   = 3'd3,
    S_CHECK = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  localparam logic [2:0] MAX_R = 3'(MAX_RETRY);

  state_t        state_q, state_d;
  logic [DW-1:0] data_q;
  logic [DW-1:0] value_q;
  logic [2:0]    retry_q;
  logic          sticky_q;
  logic [1:0]    code_q;

  logic accept;
  logic sticky_now;
  logic check_pass;
  logic can_retry;

  assign accept     = req_valid_i && (state_q == S_IDLE);
  // An update error reported in the CHECK cycle itself still fails the check.
  assign sticky_now = sticky_q | err_update_i;
  assign check_pass = (qs_i == data_q) && !sticky_now;
  assign can_retry  = (retry_q < MAX_R);

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_WR1;
      S_WR1:   state_d = S_GAP;
      S_GAP:   state_d = S_WR2;
      S_WR2:   state_d = S_CHECK;
      S_CHECK: begin
        if (!check_pass && can_retry) state_d = S_WR1;
        else                          state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: request capture, retry count, sticky error, result registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q   <= '0;
      value_q  <= RESVAL;
      retry_q  <= '0;
      sticky_q <= 1'b0;
      code_q   <= 2'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            data_q   <= req_data_i;
            retry_q  <= '0;
            sticky_q <= 1'b0;
          end
        end
        S_WR1, S_GAP, S_WR2: sticky_q <= sticky_now;
        S_CHECK: begin
          if (check_pass) begin
            value_q <= data_q;
            code_q  <= 2'd0;
          end else if (can_retry) begin
            retry_q  <= retry_q + 3'd1;
            sticky_q <= 1'b0;
          end else begin
            code_q <= sticky_now ? 2'd2 : 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    req_ready_o = 1'b0;
    we_o        = 1'b0;
    wd_o        = '0;
    done_o      = 1'b0;
    err_o       = 1'b0;
    case (state_q)
      S_IDLE:  req_ready_o = 1'b1;
      S_WR1:   begin we_o = 1'b1; wd_o = data_q; end
      S_GAP:   wd_o = data_q;
      S_WR2:   begin we_o = 1'b1; wd_o = data_q; end
      S_CHECK: wd_o = data_q;
      S_RESP:  begin done_o = 1'b1; err_o = (code_q != 2'd0); end
      default: ;
    endcase
  end

  // code_q only changes on the CHECK->RESP edge, so it is held between pulses
  assign err_code_o = code_q;
  assign value_o    = value_q;

endmodule

// File: tb/tb_shadow_reg_writer.sv
module tb_shadow_reg_writer;

  localparam int DW = 5;
  localparam logic [DW-1:0] RV = 5'b00011;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [DW-1:0] req_data = '0;
  logic          we;
  logic [DW-1:0] wd;
  logic [DW-1:0] qs;
  logic          err_update = 1'b0;
  logic          done;
  logic          err;
  logic [1:0]    err_code;
  logic [DW-1:0] value;

  always #5 clk = ~clk;

  shadow_reg_writer #(.DW(DW), .RESVAL(RV), .MAX_RETRY(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_data_i(req_data),
    .we_o(we), .wd_o(wd), .qs_i(qs), .err_update_i(err_update),
    .done_o(done), .err_o(err), .err_code_o(err_code), .value_o(value)
  );

  // Shadowed register model: first strobe stages, second strobe commits.
  logic          staged;
  logic [DW-1:0] committed;
  bit            force_qs = 1'b0;
  always @(posedge clk) begin
    if (rst) begin
      staged    <= 1'b0;
      committed <= RV;
    end else if (we) begin
      if (staged) begin
        committed <= wd;
        staged    <= 1'b0;
      end else begin
        staged <= 1'b1;
      end
    end
  end
  assign qs = force_qs ? 5'h03 : committed;

  typedef struct {
    int          lat;
    logic        err;
    logic [1:0]  code;
    logic [4:0]  val;
    logic [31:0] mask;
  } exp_t;
  exp_t sb[$];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a request in the current (IDLE) cycle and follow it to done_o.
  task automatic do_req(input logic [4:0] d, input logic [31:0] mask, input int lat,
                        input logic e, input logic [1:0] code, input logic [4:0] val,
                        input int err_off, input bit keep);
    exp_t        x;
    exp_t        got;
    bit          done_seen = 0;
    bit          wd_bad = 0;
    bit          ready_bad = 0;
    logic [31:0] strobes = '0;
    x.lat = lat; x.err = e; x.code = code; x.val = val; x.mask = mask;
    sb.push_back(x);
    req_valid = 1'b1;
    req_data  = d;
    for (int i = 1; i <= 40 && !done_seen; i++) begin
      tick();
      if (i == 1) begin
        req_data = ~d;
        if (!keep) req_valid = 1'b0;
      end
      err_update = (i == err_off);
      if (we) begin
        strobes[i] = 1'b1;
        if (wd !== d) wd_bad = 1;
      end
      if (req_ready) ready_bad = 1;
      if (done) begin
        done_seen = 1;
        got = sb.pop_front();
        chk("done_latency", 32'(i), 32'(got.lat));
        chk("err_o", {31'd0, err}, {31'd0, got.err});
        chk("err_code", {30'd0, err_code}, {30'd0, got.code});
        chk("value", {27'd0, value}, {27'd0, got.val});
        chk("strobe_cycles", strobes, got.mask);
      end
    end
    err_update = 1'b0;
    if (!done_seen) chk("done_timeout", 32'd0, 32'd1);
    chk("wd_data", {31'd0, wd_bad}, 32'd0);
    chk("ready_low_busy", {31'd0, ready_bad}, 32'd0);
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_value", {27'd0, value}, 32'h03);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_wd", {27'd0, wd}, 32'd0);
    chk("rst_code", {30'd0, err_code}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);

    // Nominal
    do_req(5'h18, 32'h0000_000A, 5, 1'b0, 2'd0, 5'h18, 0, 1'b0);
    tick();
    chk("idle_wd_zero", {27'd0, wd}, 32'd0);
    chk("idle_ready", {31'd0, req_ready}, 32'd1);

    // Readback mismatch, retries exhausted
    force_qs = 1'b1;
    do_req(5'h15, 32'h0000_0AAA, 13, 1'b1, 2'd1, 5'h18, 0, 1'b0);
    force_qs = 1'b0;
    tick();
    chk("code_held", {30'd0, err_code}, 32'd1);
    chk("err_one_cycle", {31'd0, err}, 32'd0);

    // Update error in GAP of first attempt, second attempt clean
    do_req(5'h0C, 32'h0000_00AA, 9, 1'b0, 2'd0, 5'h0C, 2, 1'b0);
    tick();

    // Mid-operation reset during GAP
    req_valid = 1'b1;
    req_data  = 5'h0A;
    tick();
    req_valid = 1'b0;
    tick();
    chk("gap_reached", {27'd0, wd}, 32'h0A);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_we", {31'd0, we}, 32'd0);
    chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_value", {27'd0, value}, 32'h03);
    do_req(5'h07, 32'h0000_000A, 5, 1'b0, 2'd0, 5'h07, 0, 1'b0);
    tick();

    // Back-to-back with valid held high
    do_req(5'h01, 32'h0000_000A, 5, 1'b0, 2'd0, 5'h01, 0, 1'b1);
    tick();
    chk("b2b_accept_ready", {31'd0, req_ready}, 32'd1);
    do_req(5'h1F, 32'h0000_000A, 5, 1'b0, 2'd0, 5'h1F, 0, 1'b0);
    tick();
    chk("final_value", {27'd0, value}, 32'h1F);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
